// File: rtl/dly_sample_pkg.sv
// Shared types and limits for the delay-sampler transmit side.
// Parameter ranges and the FSM state encoding live here so TX and tests agree.
package dly_sample_pkg;

   localparam int DW_DEF   = 32;
   localparam int HOLD_MIN = 1;
   localparam int HOLD_MAX = 255;
   localparam int GAP_MIN  = 1;
   localparam int GAP_MAX  = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } dly_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dly_hold_cnt.sv
// Hold/gap down-counter: loaded on state entry, counts down to zero and
// saturates there, flagging the last cycle of the current phase.
module dly_hold_cnt #(
   parameter int W = 8
) (
   input  logic         clka,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/dly_sample_tx.sv
// Slow-domain transmitter feeding a fast-domain delay sampler: each word is
// held on dout with dout_en high for HOLD cycles, then low for GAP cycles.
// Optional dout_par output is enabled by defining DLY_TX_PARITY_EN.
//
// state   | meaning
// IDLE    | waiting for a word; s_ready high
// HOLD    | word on dout, dout_en high for HOLD cycles
// GAP     | word still on dout, dout_en low for GAP cycles; s_ready on last
module dly_sample_tx
   import dly_sample_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int HOLD = 1,
   parameter int GAP  = 1
) (
   input  logic          clka,
   input  logic          rstn,
   input  logic [DW-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic [DW-1:0] dout,
   output logic          dout_en
`ifdef DLY_TX_PARITY_EN
   ,
   output logic          dout_par
`endif
);

   if ((HOLD < HOLD_MIN) || (HOLD > HOLD_MAX)) begin : g_bad_hold
      $fatal(1, "dly_sample_tx: HOLD out of range");
   end
   if ((GAP < GAP_MIN) || (GAP > GAP_MAX)) begin : g_bad_gap
      $fatal(1, "dly_sample_tx: GAP out of range");
   end

   localparam int CW = $clog2(max2(HOLD, GAP) + 1);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);

   dly_state_t    state, state_nxt;
   logic          live;
   logic          cnt_zero, cnt_load, cnt_dec;
   logic [CW-1:0] cnt_val;
   logic          accept;

   // live keeps s_ready low through reset and until the first edge after it
   assign s_ready = live && ((state == ST_IDLE) || ((state == ST_GAP) && cnt_zero));
   assign accept  = s_valid && s_ready;

   dly_hold_cnt #(.W(CW)) u_cnt (
      .clka     (clka),
      .rstn     (rstn),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_val   = '0;
      cnt_dec   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_HOLD;
               cnt_load  = 1'b1;
               cnt_val   = HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (cnt_zero) begin
               state_nxt = ST_GAP;
               cnt_load  = 1'b1;
               cnt_val   = GAP_LD;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_GAP: begin
            if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else if (accept) begin
               state_nxt = ST_HOLD;
               cnt_load  = 1'b1;
               cnt_val   = HOLD_LD;
            end else begin
               state_nxt = ST_IDLE;
               cnt_load  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         live    <= 1'b0;
         dout    <= '0;
         dout_en <= 1'b0;
      end else begin
         state   <= state_nxt;
         live    <= 1'b1;
         dout_en <= (state_nxt == ST_HOLD);
         if (accept) begin
            dout <= s_data;
         end
      end
   end

`ifdef DLY_TX_PARITY_EN
   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         dout_par <= 1'b0;
      end else if (accept) begin
         dout_par <= ^s_data;
      end
   end
`endif

endmodule

// File: tb/tb_dly_sample_tx.sv
// Bench for dly_sample_tx: a HOLD=1/GAP=1 and a HOLD=3/GAP=2 instance, a
// scoreboard monitor per instance and a behavioural 5x fast-clock sampler.
module tb_dly_sample_tx;

   logic clka = 1'b0;
   logic clkb = 1'b0;
   logic rstn_a = 1'b0;
   logic rstn_b = 1'b0;

   logic [31:0] a_data = '0, b_data = '0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic        a_ready, b_ready;
   logic [31:0] a_dout, b_dout;
   logic        a_en, b_en;
`ifdef DLY_TX_PARITY_EN
   logic        a_par, b_par;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] qs[$];

   always #10 clka = ~clka;
   initial begin
      #1;
      forever #2 clkb = ~clkb;
   end

   dly_sample_tx #(.DW(32), .HOLD(1), .GAP(1)) u_dut_a (
      .clka    (clka),
      .rstn    (rstn_a),
      .s_data  (a_data),
      .s_valid (a_valid),
      .s_ready (a_ready),
      .dout    (a_dout),
      .dout_en (a_en)
`ifdef DLY_TX_PARITY_EN
      ,
      .dout_par(a_par)
`endif
   );

   dly_sample_tx #(.DW(32), .HOLD(3), .GAP(2)) u_dut_b (
      .clka    (clka),
      .rstn    (rstn_b),
      .s_data  (b_data),
      .s_valid (b_valid),
      .s_ready (b_ready),
      .dout    (b_dout),
      .dout_en (b_en)
`ifdef DLY_TX_PARITY_EN
      ,
      .dout_par(b_par)
`endif
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Issue a word on instance d, waiting for s_ready; returns at the negedge after accept.
   task automatic send(input int d, input logic [31:0] w, input bit keep);
      int n = 0;
      if (d == 0) begin
         a_valid = 1'b1; a_data = w; q0.push_back(w); qs.push_back(w);
      end else begin
         b_valid = 1'b1; b_data = w; q1.push_back(w);
      end
      while (!((d == 0) ? a_ready : b_ready) && n < 100) begin
         @(negedge clka);
         n++;
      end
      if (n >= 100) begin
         total++; bad++;
         $display("FAIL send_timeout: dut %0d never raised s_ready, word %h", d, w);
      end
      @(negedge clka);
      if (!keep) begin
         if (d == 0) a_valid = 1'b0; else b_valid = 1'b0;
      end
   endtask

   // Scoreboard monitor: pops on each dout_en rise, checks pulse widths and dout stability.
   initial begin
      logic        prev[2];
      logic [31:0] word[2];
      int          hi[2], lo[2], seen[2];
      logic        en_v, rst_v;
      logic [31:0] dout_v, exp;
      int          hold_p, gap_p;
      logic        par_v;
      for (int d = 0; d < 2; d++) begin
         prev[d] = 0; word[d] = 0; hi[d] = 0; lo[d] = 0; seen[d] = 0;
      end
      forever begin
         @(negedge clka);
         for (int d = 0; d < 2; d++) begin
            en_v   = (d == 0) ? a_en : b_en;
            rst_v  = (d == 0) ? rstn_a : rstn_b;
            dout_v = (d == 0) ? a_dout : b_dout;
            hold_p = (d == 0) ? 1 : 3;
            gap_p  = (d == 0) ? 1 : 2;
`ifdef DLY_TX_PARITY_EN
            par_v  = (d == 0) ? a_par : b_par;
`else
            par_v  = 1'b0;
`endif
            if (!rst_v) begin
               prev[d] = 0; seen[d] = 0; hi[d] = 0; lo[d] = 0;
            end else begin
               if (en_v && !prev[d]) begin
                  if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                     total++; bad++;
                     $display("FAIL unexpected_word: dut %0d got %h want none", d, dout_v);
                  end else begin
                     exp = (d == 0) ? q0.pop_front() : q1.pop_front();
                     check($sformatf("dout_word_d%0d", d), dout_v, exp);
`ifdef DLY_TX_PARITY_EN
                     check($sformatf("dout_par_d%0d", d), par_v, ^exp);
`endif
                     if (seen[d] > 0) check($sformatf("gap_ge_d%0d", d), lo[d] >= gap_p, 1);
                  end
                  word[d] = dout_v; hi[d] = 1; lo[d] = 0; seen[d]++;
               end else begin
                  if (seen[d] > 0) check($sformatf("dout_stable_d%0d", d), dout_v, word[d]);
                  if (en_v) hi[d]++;
                  else begin
                     if (prev[d]) check($sformatf("hold_len_d%0d", d), hi[d], hold_p);
                     lo[d]++;
                  end
               end
               prev[d] = en_v;
            end
         end
      end
   end

   // Behavioural fast-domain sampler on clkb = 5x clka: sync dout_en, capture on its rise.
   initial begin
      logic [2:0]  sy = 3'b000;
      logic [31:0] exp;
      forever begin
         @(posedge clkb);
         if (!rstn_a) sy = 3'b000;
         else begin
            sy = {sy[1:0], a_en};
            if (sy[1] && !sy[2]) begin
               if (qs.size() == 0) begin
                  total++; bad++;
                  $display("FAIL sampler_extra: got %h want none", a_dout);
               end else begin
                  exp = qs.pop_front();
                  check("sampler_word", a_dout, exp);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b2b[3];
      logic        pat_en[6];
      logic        pat_b_en[6];
      logic        pat_b_rdy[6];
      int          k;
      b2b       = '{32'h5566740d, 32'h5566b72e, 32'h5566fa4f};
      pat_en    = '{1, 0, 1, 0, 1, 0};
      pat_b_en  = '{1, 1, 1, 0, 0, 0};
      pat_b_rdy = '{0, 0, 0, 0, 1, 1};

      repeat (3) @(negedge clka);
      check("rst_a_dout", a_dout, 0);
      check("rst_a_en", a_en, 0);
      check("rst_a_ready", a_ready, 0);
      check("rst_b_ready", b_ready, 0);
      rstn_a = 1'b1;
      rstn_b = 1'b1;
      @(negedge clka);
      check("ready_after_rst_a", a_ready, 1);
      check("ready_after_rst_b", b_ready, 1);

      // single word, HOLD=1 GAP=1
      send(0, 32'h55667788, 0);
      check("s1_en_hold", a_en, 1);
      check("s1_dout", a_dout, 32'h55667788);
      check("s1_ready_hold", a_ready, 0);
      @(negedge clka);
      check("s1_en_gap", a_en, 0);
      check("s1_ready_gap", a_ready, 1);
      @(negedge clka);
      check("s1_en_idle", a_en, 0);
      check("s1_dout_idle", a_dout, 32'h55667788);

      // back-to-back with s_valid held high
      k = 1;
      a_valid = 1'b1; a_data = b2b[0]; q0.push_back(b2b[0]); qs.push_back(b2b[0]);
      for (int i = 0; i < 6; i++) begin
         @(negedge clka);
         check($sformatf("b2b_en_%0d", i), a_en, pat_en[i]);
         if (a_ready) begin
            if (k < 3) begin
               a_data = b2b[k]; q0.push_back(b2b[k]); qs.push_back(b2b[k]); k++;
            end else a_valid = 1'b0;
         end
      end
      check("b2b_words_taken", k, 3);
      repeat (2) @(negedge clka);

`ifdef DLY_TX_PARITY_EN
      send(0, 32'h00000007, 0);
      check("par_7", a_par, 1);
      send(0, 32'h00000003, 0);
      check("par_3", a_par, 0);
      repeat (2) @(negedge clka);
`endif

      // HOLD=3 GAP=2 single word
      send(1, 32'h556614ae, 0);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("h3_en_%0d", i), b_en, pat_b_en[i]);
         check($sformatf("h3_rdy_%0d", i), b_ready, pat_b_rdy[i]);
         check($sformatf("h3_dout_%0d", i), b_dout, 32'h556614ae);
         @(negedge clka);
      end

      // reset during the 2nd HOLD cycle
      send(1, 32'h12345678, 0);
      @(negedge clka);
      check("mid_hold_en", b_en, 1);
      #2 rstn_b = 1'b0;
      #1;
      check("mid_rst_dout", b_dout, 0);
      check("mid_rst_en", b_en, 0);
      check("mid_rst_ready", b_ready, 0);
      @(negedge clka);
      #2 rstn_b = 1'b1;
      @(negedge clka);
      check("post_rst_ready", b_ready, 1);
      send(1, 32'h556689a4, 0);
      check("post_rst_dout", b_dout, 32'h556689a4);
      check("post_rst_en", b_en, 1);
      repeat (8) @(negedge clka);

      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      check("sampler_drained", qs.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
